// File: rtl/riscv_enc_pkg.sv
// Shared encodings for the program encoder: instruction format codes,
// RV32I major opcodes and the encoder FSM state type.
package riscv_enc_pkg;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_J = 3'd4;
    localparam logic [2:0] FMT_U = 3'd5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_FULL,
        ST_DONE
    } enc_state_e;

endpackage

// File: rtl/ins_field_packer.sv
// Combinational packer: scatters decoded fields into an RV32I word and
// flags bundles that cannot be encoded (bad format, odd branch/jump target).
module ins_field_packer
    import riscv_enc_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word = 32'h0;
        case (fmt)
            FMT_R: word = {1'b0, funct7b5, 5'b0, rs2, rs1, funct3, rd, opcode};
            FMT_I: begin
                // Immediate shifts carry funct7b5 in the upper immediate bits
                if (funct3 == 3'b101)
                    word = {1'b0, funct7b5, 5'b0, imm[4:0], rs1, funct3, rd, opcode};
                else
                    word = {imm[11:0], rs1, funct3, rd, opcode};
            end
            FMT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            FMT_U: word = {imm[31:12], rd, opcode};
            default: word = 32'h0;
        endcase
    end

    assign illegal = (fmt > FMT_U) | (((fmt == FMT_B) | (fmt == FMT_J)) & imm[0]);

endmodule

// File: rtl/imem_program_encoder.sv
// Packs decoded instruction bundles into RV32I words and streams them into imem.
// Optional IMEM_ENCODER_CHECKSUM_EN adds an XOR checksum of all written words.
module imem_program_encoder
    import riscv_enc_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic              funct7b5,
    input  logic [31:0]       imm,
    input  logic              finish,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err,
    output logic              done
`ifdef IMEM_ENCODER_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    localparam int                DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

    enc_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              fin_q, fin_d;
    logic              ready_q, ready_d;

    logic [31:0]       packedWord;
    logic              packedIllegal;
    logic              acceptBundle;
    logic              writeStrobe;

    ins_field_packer u_packer (
        .fmt      (fmt),
        .opcode   (opcode),
        .rd       (rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .imm      (imm),
        .word     (packedWord),
        .illegal  (packedIllegal)
    );

    assign acceptBundle = in_valid & ready_q;
    // Gated so a restart arriving during WRITE never lets the word land in imem
    assign writeStrobe  = (state_q == ST_WRITE) & ~clear & ~rst;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        fin_d   = fin_q;
        case (state_q)
            ST_IDLE: begin
                if (acceptBundle && !packedIllegal) begin
                    state_d = ST_WRITE;
                    wdata_d = packedWord;
                    fin_d   = finish;
                end else begin
                    if (acceptBundle) err_d = 1'b1;
                    if (finish) state_d = ST_DONE;
                end
            end
            ST_WRITE: begin
                addr_d  = addr_q + ADDR_W'(1);
                count_d = count_q + (ADDR_W + 1)'(1);
                fin_d   = fin_q | finish;
                if (count_d == DEPTH_C) state_d = ST_FULL;
                else if (fin_d)         state_d = ST_DONE;
                else                    state_d = ST_IDLE;
            end
            ST_FULL: begin
                if (finish || fin_q) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q <= ST_IDLE;
            addr_q  <= BASE_A;
            count_q <= '0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
            fin_q   <= 1'b0;
            ready_q <= ~rst;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            fin_q   <= fin_d;
            ready_q <= ready_d;
        end
    end

`ifdef IMEM_ENCODER_CHECKSUM_EN
    logic [31:0] chk_q;

    always_ff @(posedge clk) begin
        if (rst || clear)     chk_q <= 32'h0;
        else if (writeStrobe) chk_q <= chk_q ^ wdata_q;
    end

    assign checksum = chk_q;
`endif

    assign in_ready   = ready_q;
    assign imem_we    = writeStrobe;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign full       = (count_q == DEPTH_C);
    assign err        = err_q;
    assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_imem_program_encoder.sv
// Self-checking bench for imem_program_encoder: directed program loads,
// reject/full/finish/restart corners, then randomized bundles vs a field model.
module tb_imem_program_encoder;

    localparam int ADDR_W    = 3;
    localparam int BASE_ADDR = 5;
    localparam int DEPTH     = 8;

    logic              clk = 1'b0;
    logic              rst, clear, in_valid, in_ready;
    logic [2:0]        fmt;
    logic [6:0]        opcode;
    logic [4:0]        rd, rs1, rs2;
    logic [2:0]        funct3;
    logic              funct7b5;
    logic [31:0]       imm;
    logic              finish;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   count;
    logic              full, err, done;
`ifdef IMEM_ENCODER_CHECKSUM_EN
    logic [31:0]       checksum;
`endif

    int          checks = 0;
    int          errors = 0;
    int          expCount = 0;
    logic        expErr = 1'b0;
    logic [31:0] expChk = 32'h0;

    imem_program_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fmt        (fmt),
        .opcode     (opcode),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .imm        (imm),
        .finish     (finish),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .count      (count),
        .full       (full),
        .err        (err),
        .done       (done)
`ifdef IMEM_ENCODER_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    always #5 clk = ~clk;

    function automatic int unsigned expAddr();
        return (BASE_ADDR + expCount) % DEPTH;
    endfunction

    function automatic logic refLegal(input int unsigned f, input int unsigned im);
        if (f > 5) return 1'b0;
        if ((f == 3 || f == 4) && (im % 2 == 1)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] refEncode(input int unsigned f, input int unsigned op,
        input int unsigned d, input int unsigned s1, input int unsigned s2,
        input int unsigned f3, input int unsigned f7, input int unsigned im);
        int unsigned w;
        int unsigned iImm;
        w = op;
        case (f)
            0: w = op + (d << 7) + (f3 << 12) + (s1 << 15) + (s2 << 20) + (f7 << 30);
            1: begin
                iImm = (f3 == 5) ? ((f7 << 10) + (im % 32)) : (im % 4096);
                w = op + (d << 7) + (f3 << 12) + (s1 << 15) + (iImm << 20);
            end
            2: w = op + ((im % 32) << 7) + (f3 << 12) + (s1 << 15) + (s2 << 20)
                   + (((im / 32) % 128) << 25);
            3: w = op + (((im / 2048) % 2) << 7) + (((im / 2) % 16) << 8) + (f3 << 12)
                   + (s1 << 15) + (s2 << 20) + (((im / 32) % 64) << 25)
                   + (((im / 4096) % 2) << 31);
            4: w = op + (d << 7) + (((im / 4096) % 256) << 12) + (((im / 2048) % 2) << 20)
                   + (((im / 2) % 1024) << 21) + (((im / 1048576) % 2) << 31);
            5: w = op + (d << 7) + ((im / 4096) * 4096);
            default: w = 0;
        endcase
        return w;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic modelRestart();
        expCount = 0;
        expErr   = 1'b0;
        expChk   = 32'h0;
    endtask

    task automatic startBundle(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
        input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3, input logic f7,
        input logic [31:0] im, input logic fin, output logic ok);
        int waited;
        fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
        funct3 = f3; funct7b5 = f7; imm = im; finish = fin;
        in_valid = 1'b1;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) begin
            checkOutput("handshake_timeout", {31'b0, in_ready}, 32'h1);
            in_valid = 1'b0;
            finish   = 1'b0;
            ok       = 1'b0;
        end else begin
            @(negedge clk);
            in_valid = 1'b0;
            finish   = 1'b0;
            ok       = 1'b1;
        end
    endtask

    task automatic applyStimulus(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
        input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3, input logic f7,
        input logic [31:0] im, input logic legal, input logic [31:0] expWord, input logic fin);
        logic ok;
        startBundle(f, op, d, s1, s2, f3, f7, im, fin, ok);
        if (ok) begin
            if (legal) begin
                checkOutput("write_we", {31'b0, imem_we}, 32'h1);
                checkOutput("write_addr", {29'b0, imem_addr}, expAddr());
                checkOutput("write_wdata", imem_wdata, expWord);
                expChk = expChk ^ expWord;
                expCount++;
                @(negedge clk);
                checkOutput("we_pulse_end", {31'b0, imem_we}, 32'h0);
                checkOutput("count_after_write", {28'b0, count}, expCount);
                checkOutput("addr_after_write", {29'b0, imem_addr}, expAddr());
                checkOutput("full_after_write", {31'b0, full}, (expCount == DEPTH) ? 1 : 0);
                checkOutput("done_after_write", {31'b0, done}, {31'b0, fin});
                checkOutput("ready_after_write", {31'b0, in_ready},
                            (expCount == DEPTH || fin) ? 0 : 1);
            end else begin
                expErr = 1'b1;
                checkOutput("reject_no_we", {31'b0, imem_we}, 32'h0);
                checkOutput("reject_err", {31'b0, err}, 32'h1);
                checkOutput("reject_count", {28'b0, count}, expCount);
                checkOutput("reject_ready", {31'b0, in_ready}, 32'h1);
            end
        end
    endtask

    task automatic doClear();
        clear = 1'b1;
        @(negedge clk);
        modelRestart();
        checkOutput("clear_count", {28'b0, count}, 32'h0);
        checkOutput("clear_addr", {29'b0, imem_addr}, BASE_ADDR);
        checkOutput("clear_flags", {29'b0, full, err, done}, 32'h0);
        checkOutput("clear_ready", {31'b0, in_ready}, 32'h1);
        clear = 1'b0;
    endtask

    initial begin
        logic        ok;
        logic [2:0]  rf;
        logic [6:0]  rop;
        logic [4:0]  rrd, rr1, rr2;
        logic [2:0]  rf3;
        logic        rf7;
        logic [31:0] rim;

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; finish = 1'b0;
        fmt = 3'd0; opcode = 7'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        funct3 = 3'd0; funct7b5 = 1'b0; imm = 32'h0;
        repeat (3) @(negedge clk);
        checkOutput("reset_ready", {31'b0, in_ready}, 32'h0);
        checkOutput("reset_we", {31'b0, imem_we}, 32'h0);
        checkOutput("reset_addr", {29'b0, imem_addr}, BASE_ADDR);
        checkOutput("reset_count", {28'b0, count}, 32'h0);
        checkOutput("reset_wdata", imem_wdata, 32'h0);
        checkOutput("reset_flags", {29'b0, full, err, done}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset", {31'b0, in_ready}, 32'h1);

        // Directed program: addresses 5,6,7 then wrap to 0..3
        applyStimulus(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 1'b1, 32'h002081B3, 1'b0);
        applyStimulus(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b1, 32'h00500093, 1'b0);
        applyStimulus(3'd2, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 32'd8, 1'b1, 32'h0020A423, 1'b0);
        applyStimulus(3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFFFFFC, 1'b1, 32'hFE000EE3, 1'b0);
        applyStimulus(3'd4, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8, 1'b1, 32'h008000EF, 1'b0);
        applyStimulus(3'd5, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345000, 1'b1, 32'h123452B7, 1'b0);
        applyStimulus(3'd1, 7'b0010011, 5'd1, 5'd1, 5'd0, 3'd5, 1'b1, 32'd3, 1'b1, 32'h4030D093, 1'b0);

        applyStimulus(3'd7, 7'b0110011, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 32'd0, 1'b0, 32'h0, 1'b0);
        applyStimulus(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd3, 1'b0, 32'h0, 1'b0);
        applyStimulus(3'd1, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0, 32'd1, 1'b1, 32'h00100113, 1'b0);

        // Memory is full: a further bundle must be held off
        fmt = 3'd0; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("full_hold_ready", {31'b0, in_ready}, 32'h0);
            checkOutput("full_hold_we", {31'b0, imem_we}, 32'h0);
            checkOutput("full_hold_count", {28'b0, count}, DEPTH);
        end
        in_valid = 1'b0;
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        checkOutput("full_finish_done", {31'b0, done}, 32'h1);
        checkOutput("full_finish_flags", {30'b0, full, err}, 32'h3);
`ifdef IMEM_ENCODER_CHECKSUM_EN
        checkOutput("checksum_done", checksum, expChk);
`endif
        doClear();

        // finish in the same cycle as a transfer: the write still lands
        applyStimulus(3'd1, 7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 1'b0, 32'd7, 1'b1, 32'h00700193, 1'b1);
        doClear();

        startBundle(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd1, 1'b0, ok);
        if (ok) begin
            checkOutput("pre_clear_we", {31'b0, imem_we}, 32'h1);
            clear = 1'b1;
            #1;
            checkOutput("clear_mid_write_we", {31'b0, imem_we}, 32'h0);
            @(negedge clk);
            checkOutput("clear_mid_write_count", {28'b0, count}, 32'h0);
            checkOutput("clear_mid_write_addr", {29'b0, imem_addr}, BASE_ADDR);
            checkOutput("clear_mid_write_ready", {31'b0, in_ready}, 32'h1);
            clear = 1'b0;
        end
        modelRestart();

        startBundle(3'd5, 7'b0010111, 5'd4, 5'd0, 5'd0, 3'd0, 1'b0, 32'hABCDE000, 1'b0, ok);
        if (ok) begin
            rst = 1'b1;
            @(negedge clk);
            checkOutput("rst_mid_write_we", {31'b0, imem_we}, 32'h0);
            checkOutput("rst_mid_write_count", {28'b0, count}, 32'h0);
            checkOutput("rst_mid_write_ready", {31'b0, in_ready}, 32'h0);
            rst = 1'b0;
            @(negedge clk);
            checkOutput("rst_release_ready", {31'b0, in_ready}, 32'h1);
        end
        modelRestart();

        for (int i = 0; i < 40; i++) begin
            if (expCount == DEPTH) doClear();
            rf  = 3'($urandom_range(0, 7));
            rop = 7'($urandom);
            rrd = 5'($urandom);
            rr1 = 5'($urandom);
            rr2 = 5'($urandom);
            rf3 = 3'($urandom);
            rf7 = 1'($urandom);
            rim = $urandom;
            applyStimulus(rf, rop, rrd, rr1, rr2, rf3, rf7, rim, refLegal(rf, rim),
                          refEncode(rf, rop, rrd, rr1, rr2, rf3, rf7, rim), 1'b0);
            checkOutput("rand_err_sticky", {31'b0, err}, {31'b0, expErr});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
